// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial N-bit adder. One 1-bit full adder cell (sumcomp) is reused for
// every bit position: each RUN cycle it sees one operand bit pair plus the
// registered carry. The sum bit is shifted into a result register and the
// carry-out is registered for the next bit. One addition takes N RUN cycles
// plus a DONE cycle that publishes the result.
//
// Parameters:
//   N      operand/result width in bits (N >= 2), default 8
//
// Ports:
//   clk    in   1  system clock, rising-edge active
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request a new addition, sampled when not busy
//   a      in   N  operand A, captured on accepted start
//   b      in   N  operand B, captured on accepted start
//   cin    in   1  carry-in, captured on accepted start
//   busy   out  1  high while operand bits are being processed
//   done   out  1  one-cycle pulse when sum/cout (and ovf) are valid
//   sum    out  N  result, held until the next done
//   cout   out  1  final carry-out, held until the next done
//   ovf    out  1  signed overflow (only with SERIAL_ADDER_OVF_EN defined)
//
// Configuration macro:
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its capture logic.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sumcomp
//
// 1-bit full adder cell.
//
// Ports:
//   xi  in   1  operand bit x
//   yi  in   1  operand bit y
//   ci  in   1  carry in
//   Si  out  1  sum bit
//   Co  out  1  carry out
// ---------------------------------------------------------------------------
module sumcomp (
    input  logic xi,
    input  logic yi,
    input  logic ci,
    output logic Si,
    output logic Co
);

    assign Si = xi ^ yi ^ ci;
    assign Co = (xi & yi) | (ci & (xi ^ yi));

endmodule

module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [N-1:0]  opa;
    logic [N-1:0]  opb;
    logic [N-1:0]  acc;
    logic          carry;
    logic [CW-1:0] cnt;

    logic load;
    logic shift;
    logic finish;

    logic bit_sum;
    logic bit_carry;

    // The single full-adder cell always looks at the current LSBs and the
    // registered carry; its outputs are only used while shifting.
    sumcomp u_sumcomp (
        .xi (opa[0]),
        .yi (opb[0]),
        .ci (carry),
        .Si (bit_sum),
        .Co (bit_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control. DONE accepts a new start directly so
    // that additions can run back to back without passing through IDLE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                finish = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // busy comes straight from the state register, so no input reaches it
    // combinationally.
    assign busy = (state == RUN);

    // Operand/result shifting and result publication. When DONE also accepts
    // a new start, load overwrites the carry while finish still publishes
    // the old one; non-blocking semantics keep the two apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                opa   <= a;
                opb   <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (shift) begin
                acc   <= {bit_sum, acc[N-1:1]};
                carry <= bit_carry;
                opa   <= {1'b0, opa[N-1:1]};
                opb   <= {1'b0, opb[N-1:1]};
                cnt   <= cnt + CW'(1);
            end
            if (finish) begin
                sum  <= acc;
                cout <= carry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_carry_in;

    // Signed overflow is carry-into-MSB xor carry-out-of-MSB. The carry
    // into the MSB is the carry register during the last RUN cycle, so it
    // is snapshotted there; the carry out is the carry register in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_carry_in <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            if (shift && (cnt == LAST)) begin
                msb_carry_in <= carry;
            end
            if (finish) begin
                ovf <= msb_carry_in ^ carry;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. An 8-bit instance runs a table of
// hand-computed vectors plus sequences for start-while-busy, back-to-back
// start and reset mid-operation; a 4-bit instance is checked against all
// 512 operand/carry combinations.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int N  = 8;
    localparam int N4 = 4;

    logic         clk;
    logic         rst_n;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    logic          start4;
    logic [N4-1:0] a4;
    logic [N4-1:0] b4;
    logic          cin4;
    logic          busy4;
    logic          done4;
    logic [N4-1:0] sum4;
    logic          cout4;
`ifdef SERIAL_ADDER_OVF_EN
    logic          ovf4;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.N(N4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present operands and pulse start so it is sampled at the next rising
    // edge; returns 1 ns after that edge with start released.
    task automatic apply_stimulus(input logic [7:0] va, input logic [7:0] vb,
                                  input logic vcin);
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vcin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called 1 ns after the edge that accepted start. Counts busy samples
    // and the number of edges until done is seen.
    task automatic wait_done(input int max_cycles, output int lat,
                             output int busy_cycles, output logic found);
        lat         = 0;
        found       = 1'b0;
        busy_cycles = busy ? 1 : 0;
        for (int i = 1; i <= max_cycles && !found; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                lat   = i;
            end else if (busy) begin
                busy_cycles++;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        int   lat;
        int   bc;
        logic found;
        apply_stimulus(v.a, v.b, v.cin);
        wait_done(30, lat, bc, found);
        check_output({tag, "_done_seen"}, 32'(found), 32'd1);
        check_output({tag, "_latency"}, lat, N + 1);
        check_output({tag, "_busy_cycles"}, bc, N);
        check_output({tag, "_sum"}, 32'(sum), 32'(v.sum));
        check_output({tag, "_cout"}, 32'(cout), 32'(v.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check_output({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
`endif
        @(posedge clk);
        #1;
        check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_output({tag, "_sum_hold"}, 32'(sum), 32'(v.sum));
    endtask

    initial begin
        int   lat;
        int   bc;
        int   dones;
        logic found;
        vec_t v;
        logic [4:0] exp4;

        //          a      b      cin   sum    cout  ovf
        vecs[0]  = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[9]  = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[10] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        cin4   = 1'b0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_sum", 32'(sum), 32'd0);
        check_output("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_output("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 11; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Second start during RUN is ignored; a start in the DONE state is
        // accepted and runs straight into the next addition.
        $display("[TB] start while busy and back-to-back start");
        apply_stimulus(8'h10, 8'h20, 1'b0);
        dones = 0;
        for (int i = 1; i <= N + 1; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (i == 2) begin
                a     = 8'hAA;
                b     = 8'h55;
                start = 1'b1;
            end else if (i == 3) begin
                start = 1'b0;
            end else if (i == N) begin
                a     = 8'h01;
                b     = 8'h02;
                cin   = 1'b0;
                start = 1'b1;
            end
        end
        start = 1'b0;
        check_output("busy_start_dones", dones, 1);
        check_output("busy_start_sum", 32'(sum), 32'h30);
        check_output("busy_start_cout", 32'(cout), 32'd0);
        check_output("b2b_busy", 32'(busy), 32'd1);
        wait_done(30, lat, bc, found);
        check_output("b2b_done_seen", 32'(found), 32'd1);
        check_output("b2b_latency", lat, N + 1);
        check_output("b2b_sum", 32'(sum), 32'h03);
        check_output("b2b_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        check_output("b2b_idle_busy", 32'(busy), 32'd0);

        $display("[TB] reset mid-operation");
        apply_stimulus(8'hF0, 8'h0F, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_done", 32'(done), 32'd0);
        check_output("midrst_sum", 32'(sum), 32'd0);
        check_output("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check_output("midrst_no_activity", dones, 0);
        v = vecs[10];
        run_and_check("post_rst", v);

        $display("[TB] exhaustive 4-bit");
        for (int x = 0; x < 512; x++) begin
            @(negedge clk);
            a4     = x[3:0];
            b4     = x[7:4];
            cin4   = x[8];
            start4 = 1'b1;
            exp4   = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            @(posedge clk);
            #1;
            start4 = 1'b0;
            found  = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(posedge clk);
                #1;
                if (done4) found = 1'b1;
            end
            check_output($sformatf("exh_a%0h_b%0h_c%0d", x[3:0], x[7:4], x[8]),
                         found ? 32'({cout4, sum4}) : 32'hDEAD, 32'(exp4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
